// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: ALU op codes,
// forward-select codes, FSM states and the shadow pipeline entry.
package hazard_ctrl_pkg;

   typedef enum logic [2:0] {
      AluAddu  = 3'b000,
      AluSubu  = 3'b001,
      AluOri   = 3'b010,
      AluLoad  = 3'b011,
      AluStore = 3'b100,
      AluBeq   = 3'b101,
      AluLui   = 3'b110
   } alu_op_e;

   typedef enum logic [1:0] {
      FwdRf  = 2'b00,
      FwdWb  = 2'b01,
      FwdMem = 2'b10
   } fwd_e;

   typedef enum logic [1:0] {
      StRun     = 2'b00,
      StLdStall = 2'b01,
      StBrFlush = 2'b10
   } hz_state_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dst;
      logic       regwr;
      logic       is_load;
   } stage_t;

   function automatic logic is_load_op(input logic [2:0] aluctr);
      return aluctr == AluLoad;
   endfunction

   // A stage can supply a source operand only if it really writes a non-zero register.
   function automatic logic fwd_hit(input logic       valid,
                                    input logic       regwr,
                                    input logic [4:0] dst,
                                    input logic [4:0] src);
      return valid & regwr & (dst != 5'd0) & (dst == src);
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forward-select for one EX-stage ALU operand; the younger MEM result
// takes priority over the older WB result.
module fwd_sel
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] src,
   input  logic       mem_valid,
   input  logic       mem_regwr,
   input  logic [4:0] mem_dst,
   input  logic       wb_valid,
   input  logic       wb_regwr,
   input  logic [4:0] wb_dst,
   output logic [1:0] sel
);

   always_comb begin
      sel = FwdRf;
      if (fwd_hit(mem_valid, mem_regwr, mem_dst, src)) begin
         sel = FwdMem;
      end else if (fwd_hit(wb_valid, wb_regwr, wb_dst, src)) begin
         sel = FwdWb;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: load-use stall,
// taken-branch flush and ALU operand forwarding from a shadow tag pipeline.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_dst,
   input  logic             id_regwr,
   input  logic             id_use_rt,
   input  logic [2:0]       id_aluctr,
   input  logic             ex_br_taken,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       hz_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   stage_t    id_ent;
   stage_t    ex_q, mem_q, wb_q;
   hz_state_e state_q, state_d;
   logic      load_use;
   logic      flush;
   logic      stall;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_comb begin
      id_ent         = '0;
      id_ent.valid   = id_valid;
      id_ent.rs      = id_rs;
      id_ent.rt      = id_rt;
      id_ent.dst     = id_dst;
      id_ent.regwr   = id_regwr;
      id_ent.is_load = is_load_op(id_aluctr);
   end

   // WB-vs-ID needs no check: the register file writes in the first half-cycle.
   always_comb begin
      load_use = id_valid & ex_q.valid & ex_q.is_load & (ex_q.dst != 5'd0) &
                 ((ex_q.dst == id_rs) | (id_use_rt & (ex_q.dst == id_rt)));
   end

   // Reset masks the event outputs immediately; a flush squashes the stall
   // because the stalled instruction is being discarded anyway.
   always_comb begin
      flush = ex_br_taken & ~rst;
      stall = load_use & ~flush & ~rst;
   end

   always_comb begin
      pc_stall    = stall;
      ifid_stall  = stall;
      idex_bubble = stall;
      ifid_flush  = flush;
      idex_flush  = flush;
   end

   // Every state leaves after one cycle; only a fresh event keeps it out of RUN.
   always_comb begin
      state_d = StRun;
      if (flush) begin
         state_d = StBrFlush;
      end else if (stall) begin
         state_d = StLdStall;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         // A squashed slot is cleared entirely so its tags cannot match anything.
         if (stall || flush) begin
            ex_q <= '0;
         end else begin
            ex_q <= id_ent;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CntOne;
         end
         if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CntOne;
         end
      end
   end

   fwd_sel u_fwd_a (
      .src       (ex_q.rs),
      .mem_valid (mem_q.valid),
      .mem_regwr (mem_q.regwr),
      .mem_dst   (mem_q.dst),
      .wb_valid  (wb_q.valid),
      .wb_regwr  (wb_q.regwr),
      .wb_dst    (wb_q.dst),
      .sel       (fwd_a)
   );

   fwd_sel u_fwd_b (
      .src       (ex_q.rt),
      .mem_valid (mem_q.valid),
      .mem_regwr (mem_q.regwr),
      .mem_dst   (mem_q.dst),
      .wb_valid  (wb_q.valid),
      .wb_regwr  (wb_q.regwr),
      .wb_dst    (wb_q.dst),
      .sel       (fwd_b)
   );

   assign hz_state  = state_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   // WB source tags and load flag are kept for debug visibility only.
   logic unused_wb;
   assign unused_wb = ^{wb_q.rs, wb_q.rt, wb_q.is_load};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a rule-level model of the in-flight
// instructions is checked against the DUT every cycle, plus pinned literals.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid = 1'b0;
   logic [4:0]  id_rs = '0;
   logic [4:0]  id_rt = '0;
   logic [4:0]  id_dst = '0;
   logic        id_regwr = 1'b0;
   logic        id_use_rt = 1'b0;
   logic [2:0]  id_aluctr = '0;
   logic        ex_br_taken = 1'b0;
   logic        pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush;
   logic [1:0]  fwd_a, fwd_b, hz_state;
   logic [15:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_dst      (id_dst),
      .id_regwr    (id_regwr),
      .id_use_rt   (id_use_rt),
      .id_aluctr   (id_aluctr),
      .ex_br_taken (ex_br_taken),
      .pc_stall    (pc_stall),
      .ifid_stall  (ifid_stall),
      .idex_bubble (idex_bubble),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b),
      .hz_state    (hz_state),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   always #5 clk = ~clk;

   localparam int CMAX = 65535;
   localparam int OP_ADDU = 0, OP_SUBU = 1, OP_ORI = 2, OP_LOAD = 3, OP_BEQ = 5, OP_LUI = 6;

   typedef struct {
      bit v;
      int rs;
      int rt;
      int dst;
      bit wr;
      bit use_rt;
      int alu;
      bit br;
   } vec_t;

   // One instruction in flight as the model sees it.
   typedef struct {
      bit v;
      int rs;
      int rt;
      int dst;
      bit wr;
      bit ld;
      bit use_rt;
   } ent_t;

   ent_t empty_ent = '{0, 0, 0, 0, 0, 0, 0};
   ent_t m_ex, m_mem, m_wb;
   int   m_state, m_sc, m_fc;
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t ins(input int alu, input int rs, input int rt, input int dst,
                                input bit wr, input bit use_rt, input bit br = 1'b0);
      vec_t v;
      v = '{1'b1, rs, rt, dst, wr, use_rt, alu, br};
      return v;
   endfunction

   function automatic vec_t nop(input bit br = 1'b0);
      vec_t v;
      v = '{1'b0, 0, 0, 0, 1'b0, 1'b0, 0, br};
      return v;
   endfunction

   // Younger producer (MEM) beats older (WB); r0 is never a producer.
   function automatic int fwd_of(input int src);
      if (m_mem.v && m_mem.wr && m_mem.dst != 0 && m_mem.dst == src) return 2;
      if (m_wb.v && m_wb.wr && m_wb.dst != 0 && m_wb.dst == src) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_ex = empty_ent;
      m_mem = empty_ent;
      m_wb = empty_ent;
      m_state = 0;
      m_sc = 0;
      m_fc = 0;
   endtask

   task automatic apply(input vec_t v);
      bit haz, fl, st;
      @(negedge clk);
      id_valid    = v.v;
      id_rs       = v.rs[4:0];
      id_rt       = v.rt[4:0];
      id_dst      = v.dst[4:0];
      id_regwr    = v.wr;
      id_use_rt   = v.use_rt;
      id_aluctr   = v.alu[2:0];
      ex_br_taken = v.br;
      #1;
      haz = v.v && m_ex.v && m_ex.ld && m_ex.dst != 0 &&
            (m_ex.dst == v.rs || (v.use_rt && m_ex.dst == v.rt));
      fl = v.br;
      st = haz && !fl;
      check("pc_stall", {31'd0, pc_stall}, {31'd0, st});
      check("ifid_stall", {31'd0, ifid_stall}, {31'd0, st});
      check("idex_bubble", {31'd0, idex_bubble}, {31'd0, st});
      check("ifid_flush", {31'd0, ifid_flush}, {31'd0, fl});
      check("idex_flush", {31'd0, idex_flush}, {31'd0, fl});
      check("fwd_a", {30'd0, fwd_a}, fwd_of(m_ex.rs));
      check("fwd_b", {30'd0, fwd_b}, fwd_of(m_ex.rt));
      check("hz_state", {30'd0, hz_state}, m_state);
      check("stall_cnt", {16'd0, stall_cnt}, m_sc);
      check("flush_cnt", {16'd0, flush_cnt}, m_fc);
      if (m_mem.v && m_mem.ld && m_mem.dst != 0 &&
          (m_mem.dst == m_ex.rs || (m_ex.use_rt && m_mem.dst == m_ex.rt))) begin
         n_bad++;
         $display("FAIL mem_load_feeds_ex: load r%0d in MEM read by EX (t=%0t)",
                  m_mem.dst, $time);
      end
      @(posedge clk);
      if (st && m_sc < CMAX) m_sc++;
      if (fl && m_fc < CMAX) m_fc++;
      m_state = fl ? 2 : (st ? 1 : 0);
      m_wb  = m_mem;
      m_mem = m_ex;
      if (st || fl) m_ex = empty_ent;
      else m_ex = '{v.v, v.rs, v.rt, v.dst, v.wr, (v.alu == OP_LOAD), v.use_rt};
   endtask

   task automatic drive_nop();
      id_valid = 1'b0; id_rs = '0; id_rt = '0; id_dst = '0;
      id_regwr = 1'b0; id_use_rt = 1'b0; id_aluctr = '0; ex_br_taken = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, {29'd0, pc_stall, ifid_stall, idex_bubble}, 0);
      check({tag, "_flush"}, {30'd0, ifid_flush, idex_flush}, 0);
      check({tag, "_fwd"}, {28'd0, fwd_a, fwd_b}, 0);
      check({tag, "_hz_state"}, {30'd0, hz_state}, 0);
      check({tag, "_cnts"}, {stall_cnt, flush_cnt}, 0);
   endtask

   initial begin
      model_reset();
      drive_nop();
      #2 rst = 1'b1;
      #1 check_all_zero("por");
      @(negedge clk);
      rst = 1'b0;

      // Load-use on rs: one stall cycle, then WB forwards the loaded value.
      apply(ins(OP_LOAD, 1, 5, 5, 1, 0));
      apply(ins(OP_ADDU, 5, 6, 8, 1, 1));
      #1 check("pin_ldstall_state", {30'd0, hz_state}, 1);
      check("pin_stall_cnt1", {16'd0, stall_cnt}, 1);
      apply(ins(OP_ADDU, 5, 6, 8, 1, 1));
      #1 check("pin_lu_fwd_a", {30'd0, fwd_a}, 1);
      check("pin_lu_state_run", {30'd0, hz_state}, 0);

      // Reset while in LDSTALL, hazard instruction still sitting in ID.
      apply(ins(OP_LOAD, 1, 9, 9, 1, 0));
      apply(ins(OP_ADDU, 9, 0, 8, 1, 1));
      #1 check("pin_pre_rst_state", {30'd0, hz_state}, 1);
      @(negedge clk);
      ex_br_taken = 1'b1;
      rst = 1'b1;
      #1 check_all_zero("rst_ld");
      model_reset();
      @(negedge clk);
      drive_nop();
      rst = 1'b0;

      // Back-to-back ALU: MEM forwards both operands.
      apply(ins(OP_ADDU, 1, 2, 3, 1, 1));
      apply(ins(OP_SUBU, 3, 3, 4, 1, 1));
      #1 check("pin_b2b_fwd", {28'd0, fwd_a, fwd_b}, 32'b1010);
      check("pin_b2b_nostall", {16'd0, stall_cnt}, 0);

      // One independent instruction between: WB forwards both operands.
      apply(ins(OP_ADDU, 1, 2, 3, 1, 1));
      apply(ins(OP_ORI, 10, 11, 11, 1, 0));
      apply(ins(OP_SUBU, 3, 3, 4, 1, 1));
      #1 check("pin_gap_fwd", {28'd0, fwd_a, fwd_b}, 32'b0101);

      // r0 never forwarded.
      apply(ins(OP_ADDU, 1, 2, 0, 1, 1));
      apply(ins(OP_ORI, 0, 12, 12, 1, 0));
      #1 check("pin_r0_fwd_a", {30'd0, fwd_a}, 0);

      // Two writers of r7: MEM wins.
      apply(ins(OP_ADDU, 1, 2, 7, 1, 1));
      apply(ins(OP_ADDU, 1, 2, 7, 1, 1));
      apply(ins(OP_SUBU, 7, 1, 8, 1, 1));
      #1 check("pin_prio_fwd_a", {30'd0, fwd_a}, 2);

      // Taken BEQ: the flushed younger instruction must never forward.
      apply(ins(OP_BEQ, 1, 2, 0, 0, 1));
      apply(ins(OP_ADDU, 1, 2, 13, 1, 1, 1'b1));
      #1 check("pin_brflush_state", {30'd0, hz_state}, 2);
      check("pin_flush_cnt1", {16'd0, flush_cnt}, 1);
      apply(nop());
      apply(ins(OP_SUBU, 13, 13, 4, 1, 1));
      #1 check("pin_flushed_nofwd", {28'd0, fwd_a, fwd_b}, 0);

      // Load-use and taken branch together: flush only.
      apply(ins(OP_LOAD, 1, 14, 14, 1, 0));
      apply(ins(OP_ADDU, 14, 15, 5, 1, 1, 1'b1));
      #1 check("pin_simul_stall_cnt", {16'd0, stall_cnt}, 0);
      check("pin_simul_flush_cnt", {16'd0, flush_cnt}, 2);
      check("pin_simul_state", {30'd0, hz_state}, 2);

      // Load-use through rt, then an rt match that is not a read (LUI).
      apply(nop());
      apply(ins(OP_LOAD, 1, 15, 15, 1, 0));
      apply(ins(OP_ADDU, 20, 15, 5, 1, 1));
      #1 check("pin_rt_stall_cnt", {16'd0, stall_cnt}, 1);
      apply(ins(OP_ADDU, 20, 15, 5, 1, 1));
      apply(ins(OP_LOAD, 1, 16, 16, 1, 0));
      apply(ins(OP_LUI, 0, 16, 16, 1, 0));
      #1 check("pin_lui_nostall", {16'd0, stall_cnt}, 1);

      // Continuous flush until the flush counter saturates.
      for (int i = 0; i < 65540; i++) begin
         apply(nop(1'b1));
      end
      #1 check("pin_flush_sat", {16'd0, flush_cnt}, 32'h0000_FFFF);
      apply(nop(1'b1));
      #1 check("pin_flush_sat_hold", {16'd0, flush_cnt}, 32'h0000_FFFF);
      apply(nop());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Keeps its own shadow pipeline of destination and source register tags for EX, MEM and WB.
- Generates, in the same cycle:
  - the load-use stall,
  - the taken-BEQ flush,
  - the ALU operand-A/B forwarding selects feeding the EX-stage ALU.
- Classifies instructions from the 3-bit ALU control code decoded in ID.

Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  5  rs field of ID instruction.
- id_rt  in  5  rt field of ID instruction.
- id_dst  in  5  destination register of ID instruction (rd or rt).
- id_regwr  in  1  ID instruction writes the register file.
- id_use_rt  in  1  ID instruction reads rt as a source (ADDU, SUBU, STORE, BEQ).
- id_aluctr  in  3  ALU control of ID instruction.
- ex_br_taken  in  1  BEQ in EX compared equal.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID register.
- idex_bubble  out  1  load a NOP into ID/EX.
- ifid_flush  out  1  invalidate IF/ID.
- idex_flush  out  1  invalidate ID/EX.
- fwd_a  out  2  ALU A select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
- fwd_b  out  2  ALU B select, same encoding as fwd_a.
- hz_state  out  2  FSM state, for debug.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.
- flush_cnt  out  CNT_W  saturating count of branch flushes.

Behaviour:
- Reset (async, rst=1):
  - all shadow stage entries become invalid; FSM goes to RUN.
  - all stall/flush outputs are 0; fwd_a and fwd_b are 00; both counters are 0.
  - A reset mid-stall or mid-flush aborts it immediately.
- Shadow stage entry: {valid, rs, rt, dst, regwr, is_load}, where is_load = (aluctr==LOAD).
- Shadow advance every clock edge:
  - WB <= MEM; MEM <= EX.
  - EX <= ID fields, except EX becomes invalid on idex_bubble or idex_flush.
- Load-use hazard (combinational), all of:
  - id_valid, EX.valid, EX.is_load, EX.dst != 0;
  - (EX.dst == id_rs) or (id_use_rt and EX.dst == id_rt).
  - Effect: pc_stall=ifid_stall=idex_bubble=1 for exactly one cycle.
- Branch (combinational): ex_br_taken=1 gives ifid_flush=idex_flush=1.
  - Flush overrides stall: when both hold in the same cycle, all three stall outputs are 0.
- Forwarding for the EX-stage instruction:
  - fwd_a=10 if MEM.valid, MEM.regwr, MEM.dst != 0, MEM.dst == EX.rs.
  - Else fwd_a=01 if the same conditions hold on WB.
  - Else fwd_a=00.
  - MEM has priority over WB.
  - fwd_b uses EX.rt with identical rules.
  - Register 0 is never forwarded.
- FSM states: RUN=00, LDSTALL=01, BRFLUSH=10.
  - RUN goes to BRFLUSH on a taken branch, otherwise to LDSTALL on a load-use hazard.
  - LDSTALL and BRFLUSH both return to RUN after one cycle, unless a new event occurs in that cycle (same priority as above).
  - In LDSTALL, a hazard against the same load cannot recur because EX now holds the bubble.
- Counters:
  - stall_cnt increments on each stall cycle; flush_cnt increments on each flush cycle.
  - Both saturate at all-ones.
- Register file writes in the first half-cycle, so a WB destination matching an ID source needs no action.
- A MEM-stage load matching the EX-stage source is illegal by construction; the bench asserts it never occurs.

Decomposition:
- Shared include alu_defs.vh holds the ALU control codes: ADDU=000, SUBU=001, ORI=010, LOAD=011, STORE=100, BEQ=101, LUI=110.
- The same include holds the forward-select codes FWD_RF=00, FWD_MEM=10, FWD_WB=01, and the FSM state codes.
- One sub-module, fwd_sel: combinational forward-select logic for a single operand, instantiated twice (A and B).

Test Plan:
- Reset during LDSTALL:
  - Stimulus: assert rst while hz_state=01.
  - Response: same cycle, all outputs go to 0 and hz_state=00.
- Load-use on rs:
  - Stimulus: LOAD dst=5, then ADDU rs=5, rt=6.
  - Response: one cycle of pc_stall=ifid_stall=idex_bubble=1, then fwd_a=01 when ADDU is in EX; stall_cnt=1.
- Back-to-back ALU forwarding:
  - Stimulus: ADDU dst=3, then SUBU rs=3, rt=3.
  - Response: fwd_a=fwd_b=10, no stall.
  - Stimulus: the same with one independent instruction in between.
  - Response: fwd_a=fwd_b=01.
- Register 0 and priority:
  - Stimulus: ADDU dst=0, then ORI rs=0.
  - Response: fwd_a=00.
  - Stimulus: ADDU dst=7, ADDU dst=7, then SUBU rs=7.
  - Response: fwd_a=10 (MEM wins over WB).
- Taken BEQ:
  - Stimulus: ex_br_taken=1.
  - Response: ifid_flush=idex_flush=1 for one cycle, hz_state=10, flush_cnt=1; the younger instructions never drive forwarding.
- Simultaneous events:
  - Stimulus: load-use hazard in ID in the same cycle as ex_br_taken=1.
  - Response: flush only, stall outputs 0, stall_cnt unchanged.
  - Stimulus: preload the counter to 0xFFFF, then another flush.
  - Response: flush_cnt stays at 0xFFFF.
